match_controller: RTL and testbench

//  Sequences a best-of-N tic-tac-toe match around the board logic and the per-player score displays.
//  - Detects round outcomes (X win, O win, draw) and credits the winner with a one-cycle point pulse for the score counter.
//  - Freezes play for a hold period, then waits for the next-round button.
//  - Clears the board and alternates the starting player each round.
//  - Declares the match winner when a player reaches WIN_TARGET; a further button press starts a rematch.

---
 rtl/match_controller.sv | 121 ++++++++++++
 tb/tb_match_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Best-of-N tic-tac-toe match sequencer: detects round outcomes, issues score pulses,
// holds between rounds, alternates the starting player and declares the match winner.
module match_controller #(
  parameter int WIN_TARGET  = 3,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_win,
  input  logic               o_win,
  input  logic               board_full,
  input  logic               next_round,
  output logic               play_enable,
  output logic               board_clear,
  output logic               first_player,
  output logic               x_point,
  output logic               o_point,
  output logic [SCORE_W-1:0] x_score,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         round_result,
  output logic               match_over,
  output logic [1:0]         match_winner
);

  typedef enum logic [2:0] {S_CLEAR, S_PLAY, S_HOLD, S_WAIT, S_MATCH_OVER} state_t;

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(WIN_TARGET);

  state_t            state, state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic              x_win_q, o_win_q, next_q;
  logic              x_rise, o_rise, next_rise;
  logic              round_end, x_scores, o_scores, hold_done, at_target;
  logic              new_round, rematch;

  assign x_rise    = x_win & ~x_win_q;
  assign o_rise    = o_win & ~o_win_q;
  assign next_rise = next_round & ~next_q;

  // A rise beats board_full on the final move; simultaneous rises score nobody.
  assign round_end = (state == S_PLAY) && (x_rise || o_rise || board_full);
  assign x_scores  = round_end && x_rise && !o_rise;
  assign o_scores  = round_end && o_rise && !x_rise;
  assign hold_done = (state == S_HOLD) && (hold_cnt == '0);
  assign at_target = (x_score == TARGET) || (o_score == TARGET);
  assign new_round = (state == S_WAIT) && next_rise;
  assign rematch   = (state == S_MATCH_OVER) && next_rise;

  assign play_enable = (state == S_PLAY);
  assign board_clear = (state == S_CLEAR);
  assign match_over  = (state == S_MATCH_OVER);

  // NOTE: synchronous active-high reset matches the surrounding board logic.
  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_d;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      S_CLEAR:      state_d = S_PLAY;
      S_PLAY:       if (round_end) state_d = S_HOLD;
      S_HOLD:       if (hold_done) state_d = at_target ? S_MATCH_OVER : S_WAIT;
      S_WAIT:       if (next_rise) state_d = S_CLEAR;
      S_MATCH_OVER: if (next_rise) state_d = S_CLEAR;
      default:      state_d = S_CLEAR;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_win_q      <= 1'b0;
      o_win_q      <= 1'b0;
      next_q       <= 1'b0;
      x_point      <= 1'b0;
      o_point      <= 1'b0;
      hold_cnt     <= '0;
      x_score      <= '0;
      o_score      <= '0;
      round_result <= 2'b00;
      match_winner <= 2'b00;
      first_player <= 1'b0;
    end else begin
      x_win_q <= x_win;
      o_win_q <= o_win;
      next_q  <= next_round;
      x_point <= x_scores;
      o_point <= o_scores;

      if (round_end) begin
        hold_cnt     <= HOLD_LOAD;
        round_result <= x_scores ? 2'b01 : (o_scores ? 2'b10 : 2'b11);
      end else if (state == S_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end

      if (x_scores) x_score <= x_score + SCORE_W'(1);
      if (o_scores) o_score <= o_score + SCORE_W'(1);

      if (hold_done && at_target)
        match_winner <= (x_score == TARGET) ? 2'b01 : 2'b10;

      if (new_round) first_player <= ~first_player;

      if (rematch) begin
        x_score      <= '0;
        o_score      <= '0;
        round_result <= 2'b00;
        match_winner <= 2'b00;
        first_player <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: directed scenarios plus random stimulus,
// every output compared each cycle against an event-level match model.
module tb_match_controller;

  localparam int T    = 3;
  localparam int SW   = 3;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic x_win = 1'b0, o_win = 1'b0, board_full = 1'b0, next_round = 1'b0;
  logic play_enable, board_clear, first_player, x_point, o_point, match_over;
  logic [SW-1:0] x_score, o_score;
  logic [1:0] round_result, match_winner;

  int checks = 0;
  int failures = 0;

  match_controller #(.WIN_TARGET(T), .SCORE_W(SW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .x_win(x_win), .o_win(o_win), .board_full(board_full),
    .next_round(next_round), .play_enable(play_enable), .board_clear(board_clear),
    .first_player(first_player), .x_point(x_point), .o_point(o_point),
    .x_score(x_score), .o_score(o_score), .round_result(round_result),
    .match_over(match_over), .match_winner(match_winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Match model: phase of play plus remaining hold cycles, driven by input events.
  typedef enum int {PH_CLEAR, PH_PLAY, PH_HOLD, PH_WAIT, PH_OVER} phase_t;
  phase_t m_phase = PH_CLEAR;
  int  m_hold_left = 0, m_xs = 0, m_os = 0, m_result = 0, m_winner = 0;
  bit  m_first = 0, m_xpt = 0, m_opt = 0, started = 0;
  bit  px = 0, po = 0, pn = 0;

  always @(posedge clk) begin
    bit xr, orr, nr;
    xr = x_win && !px; orr = o_win && !po; nr = next_round && !pn;
    if (reset) begin
      m_phase = PH_CLEAR; m_xs = 0; m_os = 0; m_first = 0; m_result = 0;
      m_winner = 0; m_xpt = 0; m_opt = 0; m_hold_left = 0;
      px = 0; po = 0; pn = 0; started = 1;
    end else begin
      m_xpt = 0; m_opt = 0;
      case (m_phase)
        PH_CLEAR: m_phase = PH_PLAY;
        PH_PLAY: if (xr || orr || board_full) begin
          if (xr && !orr)      begin m_xs++; m_xpt = 1; m_result = 1; end
          else if (orr && !xr) begin m_os++; m_opt = 1; m_result = 2; end
          else                 m_result = 3;
          m_phase = PH_HOLD; m_hold_left = HOLD;
        end
        PH_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            if (m_xs == T || m_os == T) begin
              m_phase = PH_OVER; m_winner = (m_xs == T) ? 1 : 2;
            end else m_phase = PH_WAIT;
          end
        end
        PH_WAIT: if (nr) begin m_phase = PH_CLEAR; m_first = !m_first; end
        PH_OVER: if (nr) begin
          m_phase = PH_CLEAR; m_xs = 0; m_os = 0; m_result = 0; m_winner = 0; m_first = 0;
        end
        default: m_phase = PH_CLEAR;
      endcase
      px = x_win; po = o_win; pn = next_round;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("play_enable",  play_enable,  int'(m_phase == PH_PLAY));
      check("board_clear",  board_clear,  int'(m_phase == PH_CLEAR));
      check("match_over",   match_over,   int'(m_phase == PH_OVER));
      check("first_player", first_player, m_first);
      check("x_point",      x_point,      m_xpt);
      check("o_point",      o_point,      m_opt);
      check("x_score",      x_score,      m_xs);
      check("o_score",      o_score,      m_os);
      check("round_result", round_result, m_result);
      check("match_winner", match_winner, m_winner);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    next_round = 1'b1; tick(1);
    next_round = 1'b0; tick(1);
  endtask

  // From S_PLAY: one O win, then through the hold period.
  task automatic o_round();
    o_win = 1'b1; tick(1);
    o_win = 1'b0; tick(HOLD + 1);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    reset = 1'b1; tick(2);
    reset = 1'b0;
    check("lit_reset_clear", board_clear, 1);
    check("lit_reset_play0", play_enable, 0);
    tick(1);
    check("lit_reset_play", play_enable, 1);
    check("lit_reset_first", first_player, 0);
    check("lit_reset_scores", {x_score, o_score}, 0);

    // X win held 20 cycles
    x_win = 1'b1; tick(1);
    check("lit_xwin_point", x_point, 1);
    check("lit_xwin_score", x_score, 1);
    tick(1);
    check("lit_xwin_point_once", x_point, 0);
    tick(HOLD - 1);
    check("lit_xwin_waiting", play_enable, 0);
    tick(15);
    x_win = 1'b0;
    next_round = 1'b1; tick(1);
    check("lit_next_clear", board_clear, 1);
    check("lit_next_first", first_player, 1);
    next_round = 1'b0; tick(1);

    // Draw on board_full
    board_full = 1'b1; tick(1);
    check("lit_draw_result", round_result, 3);
    check("lit_draw_nopoint", {x_point, o_point}, 0);
    board_full = 1'b0; tick(HOLD + 1);
    press();

    // Priority: win on final move beats board_full
    x_win = 1'b1; board_full = 1'b1; tick(1);
    check("lit_prio_x", x_score, 2);
    x_win = 1'b0; board_full = 1'b0; tick(HOLD + 1);
    press();

    // Priority: simultaneous rises -> draw
    x_win = 1'b1; o_win = 1'b1; tick(1);
    check("lit_both_draw", round_result, 3);
    check("lit_both_nopoint", {x_point, o_point}, 0);
    x_win = 1'b0; o_win = 1'b0; tick(HOLD + 1);
    press();

    // O takes the match
    o_round(); press();
    o_round(); press();
    o_round();
    check("lit_match_oscore", o_score, 3);
    check("lit_match_over", match_over, 1);
    check("lit_match_winner", match_winner, 2);
    next_round = 1'b1; tick(1);
    check("lit_rematch_clear", board_clear, 1);
    check("lit_rematch_scores", {x_score, o_score}, 0);
    check("lit_rematch_first", first_player, 0);
    next_round = 1'b0; tick(1);

    // Ignored inputs: next_round during hold, x_win rise in wait
    x_win = 1'b1; tick(1);
    x_win = 1'b0;
    next_round = 1'b1; tick(1);
    next_round = 1'b0; tick(HOLD);
    check("lit_hold_ignore_next", play_enable, 0);
    check("lit_hold_ignore_clear", board_clear, 0);
    x_win = 1'b1; tick(2);
    check("lit_wait_ignore_x", x_score, 1);
    x_win = 1'b0; tick(1);
    press();

    // Reset mid-hold
    x_win = 1'b1; tick(2);
    reset = 1'b1; tick(1);
    reset = 1'b0; x_win = 1'b0;
    check("lit_midhold_clear", board_clear, 1);
    check("lit_midhold_score", x_score, 0);
    tick(1);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0)  x_win = ~x_win;
      if ($urandom_range(7) == 0)  o_win = ~o_win;
      if ($urandom_range(15) == 0) board_full = ~board_full;
      if ($urandom_range(3) == 0)  next_round = ~next_round;
      reset = ($urandom_range(499) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
